display_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit seven-segment display of the alarm clock. It drives the 2-bit select of the existing 4-digit 4:1 nibble mux and the active-low common anodes, and inserts dead time between digits to prevent ghosting. It also applies per-digit blink blanking for time-set mode and optional leading-zero blanking. It sits between the timekeeping/mode logic and the segment decoder/board pins.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/blink_gen.sv | 53 +++++
 rtl/display_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and constants for the display scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } scan_state_e;

    localparam logic [3:0] AN_ALL_OFF = 4'b1111;
    localparam logic [1:0] DIG_RIGHT  = 2'd0;
    localparam logic [1:0] DIG_LEFT   = 2'd3;

    // Active-low anode pattern with only the selected digit driven.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blink_gen.sv
// ============================================================================
// Module      : blink_gen
// Description : Enable-gated blink phase generator; phase restarts visible.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_gen #(
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blink_phase
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_q;
    logic             phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// Module      : display_scan_ctrl
// Description : 4-digit seven-segment scan controller with dead time,
//               blink blanking and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int DEAD_CYCLES  = 1000,
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] blink_mask,
    input  logic       lz_blank,
    input  logic [3:0] digit_val,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       frame_tick,
    output logic       blink_phase
);

    localparam int DRV_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int DED_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DRV_W-1:0] DRV_LAST = DRV_W'(DIGIT_CYCLES - 1);
    localparam logic [DED_W-1:0] DED_LAST = DED_W'(DEAD_CYCLES - 1);

    scan_state_e      state_q;
    scan_state_e      state_d;
    logic [1:0]       sel_q;
    logic [1:0]       sel_d;
    logic [DRV_W-1:0] drive_cnt_q;
    logic [DRV_W-1:0] drive_cnt_d;
    logic [DED_W-1:0] dead_cnt_q;
    logic [DED_W-1:0] dead_cnt_d;
    logic [3:0]       an_q;
    logic [3:0]       an_d;
    logic             frame_tick_q;
    logic             frame_tick_d;
    logic             blink_phase_w;
    logic             blanked;

    blink_gen #(
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_blink_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .blink_phase (blink_phase_w)
    );

    assign blanked = (blink_mask[sel_q] && !blink_phase_w)
                   || (lz_blank && (sel_q == DIG_LEFT) && (digit_val == 4'd0));

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        drive_cnt_d  = drive_cnt_q;
        dead_cnt_d   = dead_cnt_q;
        frame_tick_d = 1'b0;
        an_d         = AN_ALL_OFF;

        case (state_q)
            OFF: begin
                sel_d       = DIG_RIGHT;
                drive_cnt_d = '0;
                dead_cnt_d  = '0;
                state_d     = DRIVE;
            end
            DRIVE: begin
                if (drive_cnt_q == DRV_LAST) begin
                    state_d     = DEAD;
                    drive_cnt_d = '0;
                end else begin
                    drive_cnt_d = drive_cnt_q + DRV_W'(1);
                end
            end
            DEAD: begin
                if (dead_cnt_q == DED_LAST) begin
                    state_d      = DRIVE;
                    dead_cnt_d   = '0;
                    sel_d        = sel_q + 2'd1;
                    frame_tick_d = (sel_q == DIG_LEFT);
                end else begin
                    dead_cnt_d = dead_cnt_q + DED_W'(1);
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        // Disable abandons the slot; sel parks only once OFF is reached so
        // that it never moves while a stale anode is still registered low.
        if (!en) begin
            state_d      = OFF;
            drive_cnt_d  = '0;
            dead_cnt_d   = '0;
            frame_tick_d = 1'b0;
            sel_d        = (state_q == OFF) ? DIG_RIGHT : sel_q;
        end

        if ((state_q == DRIVE) && !blanked) begin
            an_d = an_select(sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OFF;
            sel_q        <= DIG_RIGHT;
            drive_cnt_q  <= '0;
            dead_cnt_q   <= '0;
            an_q         <= AN_ALL_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            drive_cnt_q  <= drive_cnt_d;
            dead_cnt_q   <= dead_cnt_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel         = sel_q;
    assign an          = an_q;
    assign frame_tick  = frame_tick_q;
    assign blink_phase = blink_phase_w;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int DIGIT_CYCLES = 4;
    localparam int DEAD_CYCLES  = 2;
    localparam int BLINK_CYCLES = 20;
    localparam int SLOT         = DIGIT_CYCLES + DEAD_CYCLES;
    localparam int FRAME        = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] blink_mask;
    logic       lz_blank;
    logic [3:0] digit_val;
    logic [1:0] sel;
    logic [3:0] an;
    logic       frame_tick;
    logic       blink_phase;

    logic [3:0] digs [4];
    assign digit_val = digs[sel];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .BLINK_CYCLES (BLINK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .blink_mask  (blink_mask),
        .lz_blank    (lz_blank),
        .digit_val   (digit_val),
        .sel         (sel),
        .an          (an),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [1:0] sel;
        logic       ft;
        logic       bp;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        logic       lz;
        logic [3:0] d3;
        int         ncyc;
    } seg_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    bit   inv_on = 1'b0;
    logic [1:0] sel_prev = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, req, t, $time);
        end
    endtask

    function automatic logic exp_bp(input int tt);
        return ((tt / BLINK_CYCLES) % 2) == 0;
    endfunction

    // Outputs expected at sample tt, counted in edges since en rose with
    // the scan parked in OFF; inputs are those held during cycle tt-1.
    function automatic exp_t model(input int tt, input logic [3:0] mask,
                                   input logic lz, input logic [3:0] d3);
        exp_t       e;
        int         p;
        int         slot;
        int         w;
        logic [3:0] one;
        one   = 4'b0001;
        e.sel = (tt >= 1) ? 2'(((tt - 1) / SLOT) % 4) : 2'd0;
        e.bp  = exp_bp(tt);
        e.ft  = (tt > FRAME) && (((tt - 1) % FRAME) == 0);
        e.an  = 4'b1111;
        if (tt >= 2) begin
            p    = (tt - 2) % FRAME;
            slot = p / SLOT;
            w    = p % SLOT;
            if ((w < DIGIT_CYCLES)
                && !((mask[slot] && !exp_bp(tt - 1))
                     || (lz && slot == 3 && d3 == 4'd0)))
                e.an = ~(one << slot);
        end
        return e;
    endfunction

    task automatic step_cycle(input logic [3:0] mask, input logic lz, input logic [3:0] d3);
        exp_t e;
        blink_mask = mask;
        lz_blank   = lz;
        digs[3]    = d3;
        sbq.push_back(model(t + 1, mask, lz, d3));
        @(posedge clk);
        #1;
        t++;
        e = sbq.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("frame_tick", 32'(frame_tick), 32'(e.ft));
        chk("blink_phase", 32'(blink_phase), 32'(e.bp));
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            chk("one_anode_max", 32'($countones(~an) <= 1), 32'd1);
            if (sel != sel_prev)
                chk("an_off_on_sel_change", 32'(an), 32'hF);
        end
        sel_prev <= sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t=%0d", t);
        $fatal(1);
    end

    initial begin
        seg_t segs [5];
        segs[0] = '{mask: 4'b0000, lz: 1'b0, d3: 4'h5, ncyc: 48};
        segs[1] = '{mask: 4'b0001, lz: 1'b0, d3: 4'h5, ncyc: 100};
        segs[2] = '{mask: 4'b0000, lz: 1'b1, d3: 4'h0, ncyc: 24};
        segs[3] = '{mask: 4'b0000, lz: 1'b1, d3: 4'h7, ncyc: 24};
        segs[4] = '{mask: 4'b1010, lz: 1'b1, d3: 4'h0, ncyc: 48};

        rst        = 1'b1;
        en         = 1'b0;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;
        digs[0]    = 4'h0;
        digs[1]    = 4'h3;
        digs[2]    = 4'h9;
        digs[3]    = 4'h5;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_frame_tick", 32'(frame_tick), 32'd0);
        chk("reset_blink_phase", 32'(blink_phase), 32'd1);
        inv_on = 1'b1;

        rst = 1'b0;
        en  = 1'b1;
        t   = 0;
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < segs[s].ncyc; c++)
                step_cycle(segs[s].mask, segs[s].lz, segs[s].d3);

        // Drop enable on the second driven cycle of slot 2.
        for (int i = 0; i < 2 * FRAME && ((t - 2) % FRAME) != (2 * SLOT + 1); i++)
            step_cycle(4'b0000, 1'b0, 4'h5);
        chk("pre_drop_an", 32'(an), 32'hB);
        en = 1'b0;
        @(posedge clk); #1;
        chk("drop_an_lags", 32'(an), 32'hB);
        chk("drop_sel_held", 32'(sel), 32'd2);
        chk("drop_blink_phase", 32'(blink_phase), 32'd1);
        chk("drop_frame_tick", 32'(frame_tick), 32'd0);
        @(posedge clk); #1;
        chk("off_an", 32'(an), 32'hF);
        chk("off_sel", 32'(sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("off_hold_an", 32'(an), 32'hF);
            chk("off_hold_frame_tick", 32'(frame_tick), 32'd0);
            chk("off_hold_sel", 32'(sel), 32'd0);
        end

        en = 1'b1;
        t  = 0;
        repeat (30) step_cycle(4'b0000, 1'b0, 4'h5);

        // Reset during the last DEAD cycle of slot 3, where a wrap is pending.
        for (int i = 0; i < 2 * FRAME && ((t - 2) % FRAME) != (FRAME - 2); i++)
            step_cycle(4'b0000, 1'b0, 4'h5);
        chk("pre_rst_sel", 32'(sel), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_blink_phase", 32'(blink_phase), 32'd1);
        @(posedge clk); #1;
        chk("rst_hold_an", 32'(an), 32'hF);
        chk("rst_hold_sel", 32'(sel), 32'd0);
        rst = 1'b0;
        t   = 0;
        repeat (30) step_cycle(4'b0000, 1'b0, 4'h5);

        inv_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
